// File: rtl/assoc_cache_v2.sv
// N-way set-associative write-back / write-allocate data cache.
// Optional hit/miss counters are built when ASSOC_CACHE_PERF_CNT_EN is defined.
module assoc_cache_v2 #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 3,
    parameter int TAG_ADDR_LEN  = 6,
    parameter int WAY_CNT       = 4,
    parameter int REPL_POLICY   = 0,
    localparam int MEM_ADDR_LEN = TAG_ADDR_LEN + SET_ADDR_LEN,
    localparam int LINE_SIZE    = 1 << LINE_ADDR_LEN,
    localparam int LINE_W       = 32 * LINE_SIZE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             addr,
    input  logic                    rd_req,
    input  logic                    wr_req,
    input  logic [31:0]             wr_data,
    output logic [31:0]             rd_data,
    output logic                    miss,
    output logic [MEM_ADDR_LEN-1:0] mem_addr,
    output logic                    mem_rd_req,
    output logic                    mem_wr_req,
    output logic [LINE_W-1:0]       mem_wr_line,
    input  logic [LINE_W-1:0]       mem_rd_line,
    input  logic                    mem_gnt,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
);

    localparam int SET_SIZE = 1 << SET_ADDR_LEN;
    localparam int WAY_BITS = (WAY_CNT > 1) ? $clog2(WAY_CNT) : 1;
    localparam int SET_LSB  = LINE_ADDR_LEN + 2;
    localparam int TAG_LSB  = SET_LSB + SET_ADDR_LEN;

    typedef logic [WAY_BITS-1:0] way_t;
    typedef enum logic [1:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK} state_t;

    state_t r_state, w_next;

    logic [LINE_W-1:0]       r_data  [SET_SIZE][WAY_CNT];
    logic [TAG_ADDR_LEN-1:0] r_tag   [SET_SIZE][WAY_CNT];
    logic [WAY_CNT-1:0]      r_valid [SET_SIZE];
    logic [WAY_CNT-1:0]      r_dirty [SET_SIZE];

    logic [31:0]             r_rd_data;
    logic [LINE_W-1:0]       r_mem_wr_line;
    logic [LINE_W-1:0]       r_fill_line;
    way_t                    r_victim;
    logic [TAG_ADDR_LEN-1:0] r_req_tag;
    logic [SET_ADDR_LEN-1:0] r_req_set;
    logic [MEM_ADDR_LEN-1:0] r_wb_addr;

    logic [LINE_ADDR_LEN-1:0] w_word;
    logic [SET_ADDR_LEN-1:0]  w_set;
    logic [TAG_ADDR_LEN-1:0]  w_tag;
    logic                     w_unused;
    logic                     w_req;
    logic                     w_wr;
    logic                     w_hit;
    way_t                     w_hit_way;
    logic                     w_has_inv;
    way_t                     w_inv_way;
    way_t                     w_pol_victim;
    way_t                     w_victim;
    logic                     w_vic_dirty;
    logic                     w_done;
    logic                     w_start;

    assign w_word   = addr[SET_LSB-1:2];
    assign w_set    = addr[SET_LSB +: SET_ADDR_LEN];
    assign w_tag    = addr[TAG_LSB +: TAG_ADDR_LEN];
    assign w_unused = ^{addr[31:TAG_LSB+TAG_ADDR_LEN], addr[1:0]};

    // A simultaneous read and write is serviced as a read.
    assign w_req   = rd_req | wr_req;
    assign w_wr    = wr_req & ~rd_req;
    assign w_done  = w_req & (r_state == IDLE) & w_hit;
    assign w_start = w_req & (r_state == IDLE) & ~w_hit;
    assign miss    = w_req & ~((r_state == IDLE) & w_hit);

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int i = 0; i < WAY_CNT; i++) begin
            if (r_valid[w_set][i] && r_tag[w_set][i] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = way_t'(i);
            end
        end
    end

    always_comb begin
        w_has_inv = 1'b0;
        w_inv_way = '0;
        for (int i = WAY_CNT - 1; i >= 0; i--) begin
            if (!r_valid[w_set][i]) begin
                w_has_inv = 1'b1;
                w_inv_way = way_t'(i);
            end
        end
    end

    assign w_victim    = w_has_inv ? w_inv_way : w_pol_victim;
    assign w_vic_dirty = r_valid[w_set][w_victim] & r_dirty[w_set][w_victim];

    generate
        if (WAY_CNT == 1) begin : g_dm
            assign w_pol_victim = '0;
        end else if (REPL_POLICY == 1) begin : g_fifo
            way_t r_ptr [SET_SIZE];

            assign w_pol_victim = r_ptr[w_set];

            // Every fill advances the pointer, including fills of invalid ways.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < SET_SIZE; s++) r_ptr[s] <= '0;
                end else if (r_state == SWAP_IN_OK) begin
                    r_ptr[r_req_set] <= r_ptr[r_req_set] + 1'b1;
                end
            end
        end else if (REPL_POLICY == 2) begin : g_rand
            logic [7:0] r_lfsr;

            assign w_pol_victim = r_lfsr[WAY_BITS-1:0];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_lfsr <= 8'h01;
                else     r_lfsr <= {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? 8'hB8 : 8'h00);
            end
        end else begin : g_lru
            localparam way_t AGE_MAX = way_t'(WAY_CNT - 1);
            way_t r_age [SET_SIZE][WAY_CNT];
            way_t w_best;
            way_t w_lru_vic;

            always_comb begin
                w_lru_vic = '0;
                w_best    = r_age[w_set][0];
                for (int i = 1; i < WAY_CNT; i++) begin
                    if (r_age[w_set][i] > w_best) begin
                        w_best    = r_age[w_set][i];
                        w_lru_vic = way_t'(i);
                    end
                end
            end

            assign w_pol_victim = w_lru_vic;

            // Ways no older than the touched one age by one; the touched way resets.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < SET_SIZE; s++)
                        for (int w = 0; w < WAY_CNT; w++) r_age[s][w] <= '0;
                end else if (w_done) begin
                    for (int w = 0; w < WAY_CNT; w++) begin
                        if (way_t'(w) == w_hit_way)
                            r_age[w_set][w] <= '0;
                        else if (r_age[w_set][w] <= r_age[w_set][w_hit_way] &&
                                 r_age[w_set][w] != AGE_MAX)
                            r_age[w_set][w] <= r_age[w_set][w] + 1'b1;
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        w_next     = r_state;
        mem_rd_req = 1'b0;
        mem_wr_req = 1'b0;
        mem_addr   = '0;
        unique case (r_state)
            IDLE: begin
                if (w_start) w_next = w_vic_dirty ? SWAP_OUT : SWAP_IN;
            end
            SWAP_OUT: begin
                mem_wr_req = 1'b1;
                mem_addr   = r_wb_addr;
                if (mem_gnt) w_next = SWAP_IN;
            end
            SWAP_IN: begin
                mem_rd_req = 1'b1;
                mem_addr   = {r_req_tag, r_req_set};
                if (mem_gnt) w_next = SWAP_IN_OK;
            end
            SWAP_IN_OK: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_rd_data     <= '0;
            r_mem_wr_line <= '0;
            r_victim      <= '0;
            r_req_tag     <= '0;
            r_req_set     <= '0;
            r_wb_addr     <= '0;
            for (int s = 0; s < SET_SIZE; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
            end
        end else begin
            r_state <= w_next;
            if (w_done && !w_wr)
                r_rd_data <= r_data[w_set][w_hit_way][{w_word, 5'd0} +: 32];
            if (w_done && w_wr)
                r_dirty[w_set][w_hit_way] <= 1'b1;
            if (w_start) begin
                r_victim  <= w_victim;
                r_req_tag <= w_tag;
                r_req_set <= w_set;
                r_wb_addr <= {r_tag[w_set][w_victim], w_set};
                if (w_vic_dirty) r_mem_wr_line <= r_data[w_set][w_victim];
            end
            if (r_state == SWAP_IN_OK) begin
                r_valid[r_req_set][r_victim] <= 1'b1;
                r_dirty[r_req_set][r_victim] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == SWAP_IN && mem_gnt) r_fill_line <= mem_rd_line;
        if (r_state == SWAP_IN_OK) begin
            r_data[r_req_set][r_victim] <= r_fill_line;
            r_tag[r_req_set][r_victim]  <= r_req_tag;
        end
        if (w_done && w_wr)
            r_data[w_set][w_hit_way][{w_word, 5'd0} +: 32] <= wr_data;
    end

    assign rd_data     = r_rd_data;
    assign mem_wr_line = r_mem_wr_line;

`ifdef ASSOC_CACHE_PERF_CNT_EN
    logic        r_refill;
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    // r_refill marks the access in flight so its final hit is not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refill   <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_start) begin
                r_refill   <= 1'b1;
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
            if (w_done) begin
                r_refill <= 1'b0;
                if (!r_refill) r_hit_cnt <= r_hit_cnt + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: doc/assoc_cache_v2.md
Name: assoc_cache_v2

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache between the CPU load/store port and the line-granular main memory.
- Successor to the fixed 4-way cache:
  - replacement policy is a parameter (LRU, FIFO, pseudo-random);
  - invalid ways are filled before any eviction;
  - the main-memory port is exposed instead of instantiated internally;
  - policy state updates exactly once per completed access.

Parameters:
- LINE_ADDR_LEN, 3, log2 words per line (LINE_SIZE = 2^LINE_ADDR_LEN).
- SET_ADDR_LEN, 3, log2 number of sets.
- TAG_ADDR_LEN, 6, tag width; MEM_ADDR_LEN = TAG_ADDR_LEN + SET_ADDR_LEN.
- WAY_CNT, 4, associativity; power of two, 1..16.
- REPL_POLICY, 0, victim selection: 0 = LRU, 1 = FIFO, 2 = 8-bit LFSR random.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- addr  in  32  byte address; split as {unused, tag, set, line, word[1:0]}.
- rd_req  in  1  read request; held until miss = 0.
- wr_req  in  1  write request; held until miss = 0.
- wr_data  in  32  write word.
- rd_data  out  32  read word, registered.
- miss  out  1  combinational; 1 = request not completing this cycle.
- mem_addr  out  MEM_ADDR_LEN  line address {tag, set}; 0 when idle.
- mem_rd_req  out  1  line read request.
- mem_wr_req  out  1  line write-back request.
- mem_wr_line  out  32*LINE_SIZE  write-back line; word i at [32i+31:32i].
- mem_rd_line  in  32*LINE_SIZE  refill line, same packing.
- mem_gnt  in  1  one-cycle completion pulse from main memory.
- hit_count  out  32  completed accesses that hit on first lookup.
- miss_count  out  32  accesses that required a refill.

Behaviour:
- Reset (async, immediate):
  - state = IDLE; all valid/dirty bits = 0; policy state = 0; LFSR = 8'h01.
  - rd_data = 0, mem_wr_line = 0, counters = 0.
  - mem_rd_req = mem_wr_req = 0 and mem_addr = 0 in the same cycle.
  - Reset mid SWAP_OUT/SWAP_IN abandons the transfer; dirty data is lost.
- Request rules:
  - rd_req and wr_req both high is treated as a read.
  - A request completes in the cycle it is asserted with state = IDLE and a tag match; miss = (rd_req|wr_req) & ~(IDLE & hit).
- Hit timing:
  - read: rd_data updates at the completing edge and is valid the next cycle.
  - write: the word is written and the dirty bit set at the completing edge.
- States: IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK.
- IDLE miss with request:
  - victim = lowest-index invalid way, else the policy victim;
  - victim way and requested {tag, set} are latched;
  - victim valid & dirty: go to SWAP_OUT with mem_wr_line/mem_wr_addr loaded; otherwise go to SWAP_IN.
- SWAP_OUT:
  - mem_wr_req = 1, mem_addr = victim {tag, set};
  - on mem_gnt go to SWAP_IN.
- SWAP_IN:
  - mem_rd_req = 1, mem_addr = latched {tag, set};
  - on mem_gnt capture mem_rd_line and go to SWAP_IN_OK.
- SWAP_IN_OK:
  - write the line, tag, valid = 1, dirty = 0 into the victim way;
  - FIFO: increment that set's pointer modulo WAY_CNT;
  - go to IDLE, where the held request then hits.
- Victim selection uses only latched values; addr changes during refill are a protocol violation and need not be handled.
- LRU:
  - per-way age of log2(WAY_CNT) bits;
  - on each completed access the touched way's age = 0, and younger ways increment, saturating at WAY_CNT-1;
  - victim = way with the maximum age, lowest index on a tie.
- FIFO:
  - victim = set pointer;
  - hits do not change the pointer;
  - invalid-way fills also advance it.
- Random:
  - Galois LFSR, polynomial x^8+x^6+x^5+x^4+1, stepped every cycle;
  - victim = LFSR[log2(WAY_CNT)-1:0].
- Counters:
  - miss_count increments on the IDLE->SWAP_* transition;
  - hit_count increments on a completing cycle unless that access missed (internal refill flag, cleared on completion);
  - both wrap at 2^32.
- WAY_CNT = 1: direct-mapped; policy ignored.

Optional Feature:
- Macro: ASSOC_CACHE_PERF_CNT_EN.
- Defined: hit_count and miss_count behave as above.
- Undefined: counter registers are not built; hit_count = miss_count = 0 constant.

Test Plan:
- Defaults, LRU, memory line at {tag1, set0} = 0x008 with word0 = 0x11111111:
  - read 0x100 -> miss = 1; mem_rd_req with mem_addr = 0x008; after mem_gnt+1 cycle miss = 0;
  - next-cycle rd_data = 0x11111111; miss_count = 1, hit_count = 0.
- Read 0x104 right after -> miss = 0 in the same cycle; rd_data = word1 next cycle; hit_count = 1; no mem request.
- LRU: read tags 1, 2, 3, 4 (set 0, addr = tag<<8), re-read tag1, read tag5 -> tag2's way refilled; tag1 still hits.
- FIFO (REPL_POLICY = 1): same sequence -> tag1's way refilled; a subsequent tag1 read misses.
- Write 0xDEADBEEF to 0x100, then read tags 2..5 (LRU):
  - tag1 eviction asserts mem_wr_req, mem_addr = 0x008, mem_wr_line[31:0] = 0xDEADBEEF;
  - mem_rd_req for 0x028 follows.
- Assert rst during SWAP_IN:
  - mem_rd_req drops the same cycle; counters = 0;
  - a subsequent read of 0x100 misses.
- With ASSOC_CACHE_PERF_CNT_EN undefined: both counters stay 0 throughout.
